// File: rtl/lsu_pkg.sv
// Purpose : shared width codes, FSM state type and byte-lane helpers for the
//           byte-serial load/store unit.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

  // Request width codes as seen on req_width.
  localparam logic [1:0] BYTE_W = 2'b00;
  localparam logic [1:0] HALF_W = 2'b01;
  localparam logic [1:0] WORD_W = 2'b10;
  localparam logic [1:0] BAD_W  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Number of byte accesses a request expands into; 0 for the invalid code.
  function automatic logic [2:0] byte_count(input logic [1:0] width);
    logic [2:0] n;
    case (width)
      BYTE_W:  n = 3'd1;
      HALF_W:  n = 3'd2;
      WORD_W:  n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Index of the final byte (N-1). Only meaningful for valid widths.
  function automatic logic [1:0] last_index(input logic [1:0] width);
    logic [2:0] n;
    n = byte_count(width);
    return 2'(n - 3'd1);
  endfunction

  // Select byte lane 'sel' of a right-aligned 32-bit word (lane 0 = [7:0]).
  function automatic logic [7:0] pick_byte(input logic [31:0] d, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lsu_serial_if.sv
// Purpose : bundles the request/response handshake and the byte-wide memory
//           port of lsu_serial.
// Latency : n/a (wiring only).
// Backpressure: req side valid/ready; response and memory side have none.
// Modports: slave  = the load/store unit (accepts requests, drives memory)
//           master = the pipeline/memory environment around it
interface lsu_serial_if #(
  parameter int ADDR_W = 32
);

  // Request from the pipeline memory stage.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_width;
  logic              req_usignext;
  logic [31:0]       req_wdata;

  // One-cycle response pulse.
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;

  // Byte-array data memory port.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_usignext;
  logic [1:0]        mem_width;
  logic [31:0]       mem_w_data;
  logic [31:0]       mem_r_data;

  modport slave (
    input  req_valid, req_we, req_addr, req_width, req_usignext, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_fault,
    output mem_we, mem_address, mem_usignext, mem_width, mem_w_data,
    input  mem_r_data
  );

  modport master (
    output req_valid, req_we, req_addr, req_width, req_usignext, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_fault,
    input  mem_we, mem_address, mem_usignext, mem_width, mem_w_data,
    output mem_r_data
  );

endinterface

// File: rtl/lsu_extend.sv
// Purpose : sign/zero extension of the load accumulator to 32 bits.
// Latency : combinational.
// Backpressure: none.
// Ports   : acc_i      assembled load bytes, right-aligned
//           width_i    request width code (byte/half/word)
//           usignext_i 1 = zero-extend, 0 = sign-extend
//           data_o     extended result
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] acc_i,
  input  logic [1:0]  width_i,
  input  logic        usignext_i,
  output logic [31:0] data_o
);

  logic sext;
  assign sext = ~usignext_i;

  // Bits above 8N-1 may hold stale bytes shifted in by earlier loads, so
  // they are always replaced, never passed through.
  always_comb begin
    data_o = acc_i;
    case (width_i)
      BYTE_W:  data_o = {{24{sext & acc_i[7]}},  acc_i[7:0]};
      HALF_W:  data_o = {{16{sext & acc_i[15]}}, acc_i[15:0]};
      default: data_o = acc_i;
    endcase
  end

endmodule

// File: rtl/lsu_serial.sv
// Purpose : byte-serial load/store initiator; expands a byte/half/word request
//           into big-endian single-byte memory accesses.
// Latency : accept at T, bytes on T+1..T+N, response pulse at T+N+1
//           (fault: response at T+1, no memory access).
// Backpressure: req_ready only in IDLE; response pulse cannot be stalled.
// Ports   : clk, rst_n (async active-low), bus (lsu_serial_if.slave: request,
//           response and byte memory port).
// Config  : define LSU_ALIGN_CHECK_EN to fault misaligned half/word requests;
//           by default any address is executed byte by byte.
module lsu_serial
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_serial_if.slave  bus
);

  lsu_state_e        state_q;
  logic [1:0]        idx_q;
  logic [1:0]        last_q;
  logic              we_q;
  logic              usx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        width_q;
  logic [31:0]       wdata_q;
  logic [31:0]       acc_q;
  logic              fault_q;
  logic              resp_valid_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [31:0]       mem_w_data_q;

  logic [1:0]        idx_d;
  logic [31:0]       acc_d;
  logic              misalign;
  logic              req_fault;
  logic [31:0]       ext_data;

  // The memory always returns a zero-extended byte; only [7:0] carries data.
  logic [23:0]       unused_rdata_hi;
  assign unused_rdata_hi = bus.mem_r_data[31:8];

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = ((bus.req_width == HALF_W) && bus.req_addr[0]) ||
                    ((bus.req_width == WORD_W) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_fault = (bus.req_width == BAD_W) || misalign;

  assign idx_d = idx_q + 2'd1;
  // Big-endian assembly: the first byte fetched ends up most significant.
  assign acc_d = {acc_q[23:0], bus.mem_r_data[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= 2'd0;
      last_q        <= 2'd0;
      we_q          <= 1'b0;
      usx_q         <= 1'b0;
      addr_q        <= '0;
      width_q       <= 2'b00;
      wdata_q       <= 32'h0;
      acc_q         <= 32'h0;
      fault_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_w_data_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_valid_q <= 1'b0;
          fault_q      <= 1'b0;
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            width_q <= bus.req_width;
            usx_q   <= bus.req_usignext;
            wdata_q <= bus.req_wdata;
            acc_q   <= 32'h0;
            idx_q   <= 2'd0;
            last_q  <= last_index(bus.req_width);
            if (req_fault) begin
              // Rejected requests never touch memory.
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              fault_q      <= 1'b1;
            end else begin
              // Memory outputs are registered, so byte 0 is set up here to
              // appear in the first XFER cycle.
              state_q       <= XFER;
              mem_we_q      <= bus.req_we;
              mem_address_q <= bus.req_addr;
              mem_w_data_q  <= bus.req_we
                             ? {24'h0, pick_byte(bus.req_wdata, last_index(bus.req_width))}
                             : 32'h0;
            end
          end
        end

        XFER: begin
          if (!we_q) begin
            acc_q <= acc_d;
          end
          if (idx_q == last_q) begin
            state_q       <= RESP;
            resp_valid_q  <= 1'b1;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_w_data_q  <= 32'h0;
          end else begin
            idx_q         <= idx_d;
            // Address arithmetic wraps modulo 2^ADDR_W by construction.
            mem_address_q <= addr_q + ADDR_W'(idx_d);
            // Stores go out MSB first: lane N-1-idx of the latched data.
            mem_w_data_q  <= we_q ? {24'h0, pick_byte(wdata_q, last_q - idx_d)} : 32'h0;
          end
        end

        RESP: begin
          resp_valid_q <= 1'b0;
          fault_q      <= 1'b0;
          state_q      <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  lsu_extend u_extend (
    .acc_i      (acc_q),
    .width_i    (width_q),
    .usignext_i (usx_q),
    .data_o     (ext_data)
  );

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_fault   = fault_q;
  // Stores and faults return zero; data is only presented during the pulse.
  assign bus.resp_rdata   = (resp_valid_q && !we_q && !fault_q) ? ext_data : 32'h0;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_address  = mem_address_q;
  assign bus.mem_w_data   = mem_w_data_q;
  assign bus.mem_width    = BYTE_W;
  assign bus.mem_usignext = 1'b1;

endmodule

// File: tb/tb_lsu_serial.sv
module tb_lsu_serial;

  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lsu_serial_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_serial #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected value of every observable output for one clock cycle.
  typedef struct packed {
    logic        ready;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        rv;
    logic [31:0] rd;
    logic        flt;
    logic [1:0]  mw;
    logic        mus;
  } exp_t;

  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;

  logic [7:0] env_mem [logic [31:0]];  // memory the DUT actually talks to
  logic [7:0] ref_mem [logic [31:0]];  // memory as the model believes it is

  logic [31:0] last_rdata;
  logic        last_fault;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic exp_t base_exp(input logic rdy);
    exp_t e;
    e = '0;
    e.ready = rdy;
    e.mus = 1'b1;
    return e;
  endfunction

  // Keep the low N bytes, then sign- or zero-extend from bit 8N-1.
  function automatic logic [31:0] extend(input logic [31:0] v, input int n, input logic usx);
    logic [63:0] m;
    logic [31:0] r;
    m = (64'd1 << (8 * n)) - 64'd1;
    r = v & m[31:0];
    if (!usx && r[8 * n - 1]) r = r | ~m[31:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Byte-array memory: commits writes seen during a cycle, returns the byte
  // at the current address zero-extended.
  initial begin
    bus.mem_r_data = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_we) env_mem[bus.mem_address] = bus.mem_w_data[7:0];
      bus.mem_r_data = {24'h0, env_rd(bus.mem_address)};
    end
  end

  // Per-cycle comparison against the expected timeline.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      a.ready = bus.req_ready;
      a.mwe   = bus.mem_we;
      a.maddr = bus.mem_address;
      a.mwd   = bus.mem_w_data;
      a.rv    = bus.resp_valid;
      a.rd    = bus.resp_rdata;
      a.flt   = bus.resp_fault;
      a.mw    = bus.mem_width;
      a.mus   = bus.mem_usignext;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = base_exp(1'b1);
      // Write data is only defined while a store byte is on the port.
      if (!e.mwe) begin
        a.mwd = 32'h0;
        e.mwd = 32'h0;
      end
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle@%0t: got rdy=%b we=%b addr=%h wd=%h rv=%b rd=%h flt=%b w=%b us=%b expected rdy=%b we=%b addr=%h wd=%h rv=%b rd=%h flt=%b w=%b us=%b",
                 $time, a.ready, a.mwe, a.maddr, a.mwd, a.rv, a.rd, a.flt, a.mw, a.mus,
                 e.ready, e.mwe, e.maddr, e.mwd, e.rv, e.rd, e.flt, e.mw, e.mus);
      end
      if (bus.resp_valid) begin
        last_rdata = bus.resp_rdata;
        last_fault = bus.resp_fault;
      end
    end
  end

  // Issue one request starting at an idle cycle (called #1 after a rising
  // edge). abort_after > 0 pulses reset after that many bytes have committed.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] width,
                        input logic usx, input logic [31:0] wdata, input int abort_after);
    int          n;
    int          cycles;
    logic        flt;
    logic [31:0] val;
    logic [31:0] a;
    logic [7:0]  b;
    exp_t        e;

    n = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : (width == 2'd2) ? 4 : 0;
    flt = (width == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
    if ((width == 2'd1 && addr[0]) || (width == 2'd2 && addr[1:0] != 2'b00)) flt = 1'b1;
`endif
    last_rdata = 32'hxxxxxxxx;
    last_fault = 1'bx;
    val = 32'h0;

    exp_q.push_back(base_exp(1'b1));
    if (flt) begin
      e = base_exp(1'b0);
      e.rv = 1'b1;
      e.flt = 1'b1;
      exp_q.push_back(e);
      cycles = 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (abort_after > 0 && i >= abort_after) break;
        a = addr + 32'(i);
        e = base_exp(1'b0);
        e.mwe = we;
        e.maddr = a;
        if (we) begin
          b = 8'(wdata >> (8 * (n - 1 - i)));
          e.mwd = {24'h0, b};
          ref_mem[a] = b;
        end else begin
          val = (val << 8) | {24'h0, ref_rd(a)};
        end
        exp_q.push_back(e);
      end
      if (abort_after == 0) begin
        e = base_exp(1'b0);
        e.rv = 1'b1;
        e.rd = we ? 32'h0 : extend(val, n, usx);
        exp_q.push_back(e);
      end
      cycles = n + 2;
    end

    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_width    = width;
    bus.req_usignext = usx;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    // Inputs outside IDLE must be ignored; keep valid up with junk fields.
    bus.req_we       = ~we;
    bus.req_addr     = $urandom;
    bus.req_width    = 2'($urandom_range(3, 0));
    bus.req_usignext = ~usx;
    bus.req_wdata    = $urandom;

    if (abort_after > 0) begin
      repeat (abort_after) begin
        @(posedge clk);
        #1;
      end
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      check("abort_ready", {31'h0, bus.req_ready}, 32'h1);
      check("abort_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      check("abort_mem_we", {31'h0, bus.mem_we}, 32'h0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
    end else begin
      repeat (cycles - 2) begin
        @(posedge clk);
        #1;
      end
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_width    = 2'b00;
    bus.req_usignext = 1'b0;
    bus.req_wdata    = 32'h0;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 32'({bus.req_ready, bus.resp_valid, bus.resp_fault, bus.mem_we,
                              bus.mem_width, bus.mem_usignext}), 32'b1000001);
    check("reset_rdata", bus.resp_rdata, 32'h0);
    check("reset_maddr", bus.mem_address, 32'h0);
    check("reset_wdata", bus.mem_w_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word store then read back, plus extensions of parts of it.
    do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0);
    check("store_rdata", last_rdata, 32'h0);
    check("store_fault", {31'h0, last_fault}, 32'h0);
    check("store_bytes", {env_rd(32'h10), env_rd(32'h11), env_rd(32'h12), env_rd(32'h13)}, 32'hDEADBEEF);
    do_req(1'b0, 32'h10, 2'b10, 1'b1, 32'h0, 0);
    check("load_word", last_rdata, 32'hDEADBEEF);
    do_req(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 0);
    check("load_half_s", last_rdata, 32'hFFFFBEEF);
    do_req(1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 0);
    check("load_half_u", last_rdata, 32'h0000BEEF);
    do_req(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0);
    check("load_byte_s", last_rdata, 32'hFFFFFFEF);
    do_req(1'b0, 32'h10, 2'b00, 1'b1, 32'h0, 0);
    check("load_byte_u", last_rdata, 32'h000000DE);

    // Invalid width store: fault, no write.
    do_req(1'b1, 32'h40, 2'b11, 1'b0, 32'h12345678, 0);
    check("bad_width_fault", {31'h0, last_fault}, 32'h1);
    check("bad_width_rdata", last_rdata, 32'h0);
    check("bad_width_nowrite", {31'h0, env_mem.exists(32'h40)}, 32'h0);

    // Misaligned word load.
    do_req(1'b0, 32'h11, 2'b10, 1'b1, 32'h0, 0);
`ifdef LSU_ALIGN_CHECK_EN
    check("misalign_fault", {31'h0, last_fault}, 32'h1);
`else
    check("misalign_load", last_rdata, 32'hADBEEF4E);
`endif

    // Half and byte stores; only the low N bytes of wdata are used.
    do_req(1'b1, 32'h20, 2'b01, 1'b0, 32'hFFFF1234, 0);
    do_req(1'b0, 32'h20, 2'b01, 1'b1, 32'h0, 0);
    check("half_roundtrip", last_rdata, 32'h00001234);
    do_req(1'b1, 32'h31, 2'b00, 1'b0, 32'hAAAAAA80, 0);
    do_req(1'b0, 32'h31, 2'b00, 1'b0, 32'h0, 0);
    check("byte_roundtrip", last_rdata, 32'hFFFFFF80);

    // Reset after two bytes of a word store: those two stay written.
    do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hCAFEF00D, 2);
    check("abort_bytes", {env_rd(32'h10), env_rd(32'h11), env_rd(32'h12), env_rd(32'h13)}, 32'hCAFEBEEF);
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0);
    check("abort_reload", last_rdata, 32'hCAFEBEEF);

    // Address wrap at the top of the address space.
    do_req(1'b1, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h11223344, 0);
`ifdef LSU_ALIGN_CHECK_EN
    check("wrap_fault", {31'h0, last_fault}, 32'h1);
    check("wrap_nowrite", {31'h0, env_mem.exists(32'h0)}, 32'h0);
`else
    check("wrap_bytes", {env_rd(32'hFFFFFFFF), env_rd(32'h0), env_rd(32'h1), env_rd(32'h2)}, 32'h11223344);
    do_req(1'b0, 32'h2, 2'b00, 1'b1, 32'h0, 0);
    check("wrap_reload", last_rdata, 32'h00000044);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_serial.md
# lsu_serial

Byte-serial load/store initiator sitting between the pipeline memory stage and the byte-array data memory. Accepts one load or store per handshake, issues it as a sequence of single-byte accesses on the memory port (always byte width, zero-extended), assembles big-endian load data, and returns a one-cycle response. Drives the memory's write-enable, address, width, sign-control and write-data inputs and consumes its read data.

## Interface
Parameters:
- ADDR_W, 32, address width of request and memory port

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address of first (most significant) byte
- req_width  in  2  00 byte, 01 half, 10 word, 11 invalid
- req_usignext  in  1  load zero-extend when 1, sign-extend when 0
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse, no backpressure
- resp_rdata  out  32  extended load data (0 for stores/faults)
- resp_fault  out  1  request rejected, no memory access made
- mem_we  out  1  memory write enable
- mem_address  out  ADDR_W  memory byte address
- mem_usignext  out  1  constant 1
- mem_width  out  2  constant 00 (byte)
- mem_w_data  out  32  store byte in [7:0], [31:8] = 0
- mem_r_data  in  32  memory read data (byte in [7:0])

## Operation
- States: IDLE, XFER, RESP.
- IDLE: req_ready=1. On req_valid: latch we, addr, width, usignext, wdata; count N = 1/2/4 bytes; idx=0; go XFER. Width 11 (or alignment fault, see Configuration): go RESP directly with fault=1.
- XFER: one byte per cycle. mem_address = base + idx (mod 2^ADDR_W, wraps silently). mem_we = latched we.
  - Store: mem_w_data[7:0] = wdata[8*(N-1-idx) +: 8] (MSB first).
  - Load: acc <= {acc[23:0], mem_r_data[7:0]}.
  - idx == N-1 → RESP; else idx+1.
- RESP: resp_valid=1 for exactly one cycle; go IDLE.
  - Load: resp_rdata = acc low N bytes, sign- or zero-extended per usignext from bit 8N-1.
  - Store or fault: resp_rdata=0.
- Outside XFER: mem_we=0, mem_address=0, mem_w_data=0.
- Reset (any state, mid-transfer included): state IDLE, acc/idx/latched fields 0; partially written bytes of an aborted store stay written.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_we=0, mem_address=0, mem_w_data=0, mem_width=00, mem_usignext=1.

## Timing
- Accept on cycle T (req_valid & req_ready). Byte accesses on cycles T+1..T+N. resp_valid on T+N+1. Next accept earliest T+N+2.
- Fault: resp_valid on T+1, no memory cycle.
- Stores commit each byte at the rising edge ending its XFER cycle.
- Loads sample mem_r_data combinationally in the same XFER cycle as mem_address.
- Request inputs are ignored outside IDLE; req_valid need not drop.

## Configuration
- LSU_ALIGN_CHECK_EN defined: half with addr[0]≠0 or word with addr[1:0]≠0 → fault response at T+1, no memory access.
- Undefined: any address is accepted and executed byte-serially; only width 11 faults.

## Structure
- Shared package lsu_pkg: width codes BYTE_W=00, HALF_W=01, WORD_W=10; state enum IDLE/XFER/RESP; byte-count function width→N.
- Sub-module lsu_extend: combinational width/usignext extension of the accumulator for resp_rdata.

## Test plan
- Store word 0xDEADBEEF at 0x10 → mem_we high 4 cycles, addresses 0x10..0x13, bytes DE,AD,BE,EF; resp_valid at T+5, rdata 0, fault 0.
- Load word 0x10 after above → resp_rdata 0xDEADBEEF at T+5.
- Load half 0x12 usignext=0 → 0xFFFFBEEF; usignext=1 → 0x0000BEEF; load byte 0x13 signed → 0xFFFFFFEF.
- Width 11 → resp_valid at T+1, fault 1, mem_we never asserted.
- Load word 0x11: with LSU_ALIGN_CHECK_EN → fault at T+1; without → rdata 0xADBEEF00-region value from bytes 0x11..0x14.
- rst_n low during cycle 2 of word store → only 0x10, 0x11 written, req_ready=1 and resp_valid=0 immediately; address 0xFFFFFFFF word store (no check) wraps to 0x0..0x2.
